// File: rtl/fib_pkg.sv
// fib_pkg: shared types and helpers for the stack-based recurrence engine.
// Contents: FSM state enum, mode constants, recurrence order and base-value helpers.
// Imported by fib_stack_engine; fib_stack is type-agnostic and does not need it.
package fib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    POP,
    EVAL,
    PUSH2,
    PUSH3,
    DONE
  } state_e;

  localparam logic MODE_FIB  = 1'b0;
  localparam logic MODE_TRIB = 1'b1;

  // Recurrence order K for the requested mode: 2 for Fibonacci, 3 for Tribonacci.
  function automatic logic [1:0] order_of(input logic mode);
    return (mode == MODE_TRIB) ? 2'd3 : 2'd2;
  endfunction

  // Leaf value of the recursion tree: F(0)=0, F(m)=1 for 1<=m<K.
  // Only meaningful for cur < K; the engine never asks otherwise.
  function automatic logic base_val(input logic [31:0] cur, input logic [1:0] k);
    return (cur != 32'd0) && (cur < {30'd0, k});
  endfunction

endpackage

// File: rtl/fib_stack.sv
// fib_stack: parametrised LIFO of DW-bit entries, DEPTH deep, registered stack pointer.
// Ports: clk/rst (sync, active-low), clr empties the stack, push/din write, pop discards top,
//        top shows the most recent entry, empty/full status. Push while full is dropped.
module fib_stack #(
  parameter int DW    = 5,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] top,
  output logic          empty,
  output logic          full
);

  // Address width for the storage; pointer needs one extra value to represent "full".
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [PW-1:0] top_idx;

  assign top_idx = sp_q - PW'(1);
  assign top     = mem_q[top_idx[AW-1:0]];
  assign empty   = (sp_q == '0);
  assign full    = (sp_q == PW'(DEPTH));

  always_comb begin
    sp_d = sp_q;
    if (clr) begin
      sp_d = '0;
    end else if (push && !full) begin
      sp_d = sp_q + PW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage carries no reset: only entries below the pointer are ever read.
  always_ff @(posedge clk) begin
    if (rst && !clr && push && !full) begin
      mem_q[sp_q[AW-1:0]] <= din;
    end
  end

  // The engine sequences pushes and pops in separate states.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push && pop));
    end
  end

endmodule

// File: rtl/fib_stack_engine.sv
// fib_stack_engine: evaluates order-K additive recurrences (K=2 Fibonacci, K=3 Tribonacci)
// by expanding the recursion tree on an explicit LIFO and summing leaf values.
// Ports: start/mode/n request (sampled in IDLE), busy/done handshake, result/ovf/err outputs;
//        optional cycles perf counter when FIB_PERF_CNT_EN is defined.
module fib_stack_engine
  import fib_pkg::*;
#(
  parameter int N_W         = 5,
  parameter int RES_W       = 64,
  parameter int STACK_DEPTH = 64
`ifdef FIB_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [N_W-1:0]   n,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             ovf,
  output logic             err
`ifdef FIB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);

  state_e           state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic             mode_q, mode_d;
  logic [N_W-1:0]   cur_q, cur_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [RES_W-1:0] result_q, result_d;

  logic [1:0]       k;
  logic [N_W-1:0]   k_w;
  logic [RES_W:0]   sum_w;

  logic             push_req;
  logic [N_W-1:0]   push_val;
  logic             stk_push, stk_pop, stk_clr;
  logic [N_W-1:0]   stk_top;
  logic             stk_empty, stk_full;

  assign k   = order_of(mode_q);
  assign k_w = N_W'(k);

  fib_stack #(
    .DW    (N_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (push_val),
    .top   (stk_top),
    .empty (stk_empty),
    .full  (stk_full)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    mode_d    = mode_q;
    cur_d     = cur_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    result_d  = result_q;
    push_req  = 1'b0;
    push_val  = '0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clr   = 1'b0;
    sum_w     = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n;
          mode_d  = mode;
          acc_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          // A previous job may have aborted on a full stack with entries left behind.
          stk_clr = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        push_req = 1'b1;
        push_val = n_q;
        state_d  = POP;
      end
      POP: begin
        if (stk_empty) begin
          state_d = DONE;
        end else begin
          cur_d   = stk_top;
          stk_pop = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (cur_q < k_w) begin
          // Leaf: add its base value; the carry out of the top bit feeds sticky ovf.
          sum_w   = {1'b0, acc_q} + {{RES_W{1'b0}}, base_val(32'(cur_q), k)};
          acc_d   = sum_w[RES_W-1:0];
          ovf_d   = ovf_q | sum_w[RES_W];
          state_d = POP;
        end else begin
          push_req = 1'b1;
          push_val = cur_q - N_W'(1);
          state_d  = PUSH2;
        end
      end
      PUSH2: begin
        push_req = 1'b1;
        push_val = cur_q - N_W'(2);
        state_d  = (k == 2'd3) ? PUSH3 : POP;
      end
      PUSH3: begin
        push_req = 1'b1;
        push_val = cur_q - N_W'(3);
        state_d  = POP;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A push into a full stack aborts the job: nothing is written, err is raised
    // and the FSM goes straight to DONE.
    if (push_req) begin
      if (stk_full) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        stk_push = 1'b1;
      end
    end

    // Capture the result on entry to DONE so it is already valid in the done cycle.
    if (state_d == DONE && state_q != DONE) begin
      result_d = err_d ? '0 : acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      mode_q   <= MODE_FIB;
      cur_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      cur_q    <= cur_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

`ifdef FIB_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Every non-IDLE cycle (LOAD through DONE) is counted; the value holds in IDLE.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (start) begin
        cnt_d = '0;
      end
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycles = cnt_q;
`endif

endmodule

// File: doc/fib_stack_engine.md
Name: fib_stack_engine

Overview:
- Parametrised successor to the stack-based customised Fibonacci unit.
- Evaluates order-K additive recurrences (K=2 Fibonacci, K=3 Tribonacci, selected per request) by explicit-stack recursion expansion.
- Configurable argument width, result width and stack depth; adds start/busy/done handshake, overflow and stack-error reporting.
- Sits as a slave compute block behind a request/response controller.

Parameters:
- N_W, 5, argument width.
- RES_W, 64, result/accumulator width.
- STACK_DEPTH, 64, LIFO entries (each N_W bits).
- CNT_W, 32, perf-counter width (only with optional feature).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low
- start  in  1  request strobe, sampled only in IDLE
- mode  in  1  0=Fibonacci (K=2), 1=Tribonacci (K=3); latched with start
- n  in  N_W  argument; latched with start
- busy  out  1  high from LOAD through DONE
- done  out  1  one-cycle pulse; result/ovf/err valid from this cycle
- result  out  RES_W  F(n) mod 2^RES_W; held until next accepted start
- ovf  out  1  sticky: any accumulate carried out of RES_W
- err  out  1  stack overflow; result forced 0

Behaviour:
- Reset (rst=0 at edge): state=IDLE, stack pointer=0, busy=0, done=0, result=0, ovf=0, err=0. Applies mid-operation; in-flight job discarded.
- Base values: F(0)=0; F(m)=1 for 1<=m<K.
- States:
  - IDLE: start=1 -> latch n/mode, acc=0, ovf=0, err=0 -> LOAD.
  - LOAD: push n -> POP.
  - POP: empty -> DONE; else cur=top, sp-- -> EVAL.
  - EVAL: cur<K -> acc+=base(cur), ovf|=carry -> POP. Else push cur-1 -> PUSH2.
  - PUSH2: push cur-2 -> (K=3 ? PUSH3 : POP).
  - PUSH3: push cur-3 -> POP.
  - DONE: done=1, result=acc (0 if err) -> IDLE.
- Any push with sp==STACK_DEPTH: no write, err=1 -> DONE next cycle.
- start outside IDLE ignored; n/mode changes after acceptance ignored.
- start in the DONE cycle is ignored; it is accepted only in IDLE, the cycle after done.
- Arithmetic: accumulator is RES_W bits unsigned, wrapping; ovf is sticky per job.
- Latency: n=0 gives done in the 5th cycle after the start-sampling edge. Generally 2 + per node (POP+EVAL) + K-1 push cycles per internal node + 1.

Optional Feature:
- Macro FIB_PERF_CNT_EN.
- Defined: adds output cycles [CNT_W-1:0]. Cleared on accepted start; counts every cycle LOAD..DONE inclusive; holds afterwards; reset 0; saturates at all-ones.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package fib_pkg:
  - state enum (IDLE, LOAD, POP, EVAL, PUSH2, PUSH3, DONE)
  - mode constants MODE_FIB=0, MODE_TRIB=1
  - function order_of(mode)
  - function base_val(cur, K)
- Sub-module fib_stack: parametrised LIFO.
  - push/pop/din/top/empty/full, synchronous active-low reset.
  - Simultaneous push+pop not used by the engine; assert it never occurs.

Test Plan:
- Fibonacci: mode=0, n=10 -> done pulse once, result=55, ovf=0, err=0, busy low the cycle after done.
- Tribonacci: mode=1, n=7 -> result=24. Then n=0 -> result=0 with done in the 5th cycle after start; n=2 -> result=1.
- Overflow: RES_W=8, mode=0, n=14 -> result=121 (377 mod 256), ovf=1, err=0.
- Stack error: STACK_DEPTH=4, mode=0, n=20 -> err=1, result=0, done asserted. A following n=5 job -> result=5, err=0.
- Control edges:
  - start pulsed while busy with different n -> ignored, original result kept.
  - rst=0 during EVAL -> next cycle busy=0, done=0, result=0; a fresh n=6 job -> result=8.
  - With FIB_PERF_CNT_EN, n=0 -> cycles=5.
